// File: rtl/soc_bus_pkg.sv
// soc_bus_pkg
// Shared definitions for the SOC memory/peripheral bus: default bus widths,
// the arbiter state encoding, the master index type and the round-robin
// winner pick used by mem_bus_arbiter. The SOC address decode also imports
// this package for the default widths.
package soc_bus_pkg;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_t;

   typedef logic master_idx_t;

   // A lone requester always wins; on a tie the master that was not served
   // most recently goes next, so neither side can starve the other.
   function automatic master_idx_t pickWinner(input logic req0,
                                              input logic req1,
                                              input master_idx_t last);
      if (req0 && req1) begin
         return ~last;
      end else if (req1) begin
         return 1'b1;
      end else begin
         return 1'b0;
      end
   endfunction

endpackage

// File: rtl/bus_timeout_ctr.sv
// bus_timeout_ctr
// Saturating watchdog counter for bus bridges waiting on a slave handshake.
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high; clears the count
//   clear_i    restart the count at zero (a new access begins)
//   en_i       one more cycle has passed without the slave answering
//   expired_o  high on the enabled cycle whose count reaches TIMEOUT
// TIMEOUT = 0 disables the watchdog: expired_o never rises.
module bus_timeout_ctr #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   // The count stops at LIMIT instead of wrapping, so a stuck access can
   // never roll the counter back to a small value.
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (en_i && (count_q != LIMIT)) begin
         count_d = count_q + 1'b1;
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Expiry is flagged in the same cycle the count would reach LIMIT, so the
   // owner can leave its wait state on the following edge.
   assign expired_o = (TIMEOUT != 0) && en_i && (count_d == LIMIT);

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares the single-port SOC bus between the CPU (master 0) and a secondary
// requester (master 1). Accesses are serialised with round-robin priority,
// the granted request is registered onto the slave side and the response is
// returned to the winner one cycle after the slave completes. A watchdog
// ends any access the slave never acknowledges.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   m{0,1}_req/_we/_addr/_wdata/_wstrb   master request, held until ready
//   m{0,1}_ready/_rdata/_err         one-cycle completion pulse to owner
//   s_req/_we/_addr/_wdata/_wstrb    registered copy of the granted request
//   s_ready, s_rdata                 slave completion and read data
module mem_bus_arbiter
   import soc_bus_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                m0_req,
   input  logic                m0_we,
   input  logic [ADDR_W-1:0]   m0_addr,
   input  logic [DATA_W-1:0]   m0_wdata,
   input  logic [DATA_W/8-1:0] m0_wstrb,
   output logic                m0_ready,
   output logic [DATA_W-1:0]   m0_rdata,
   output logic                m0_err,
   input  logic                m1_req,
   input  logic                m1_we,
   input  logic [ADDR_W-1:0]   m1_addr,
   input  logic [DATA_W-1:0]   m1_wdata,
   input  logic [DATA_W/8-1:0] m1_wstrb,
   output logic                m1_ready,
   output logic [DATA_W-1:0]   m1_rdata,
   output logic                m1_err,
   output logic                s_req,
   output logic                s_we,
   output logic [ADDR_W-1:0]   s_addr,
   output logic [DATA_W-1:0]   s_wdata,
   output logic [DATA_W/8-1:0] s_wstrb,
   input  logic                s_ready,
   input  logic [DATA_W-1:0]   s_rdata
);

   localparam int STRB_W = DATA_W / 8;

   arb_state_t          state_q, state_d;
   master_idx_t         owner_q, owner_d;
   master_idx_t         last_q, last_d;
   logic                sWe_q, sWe_d;
   logic [ADDR_W-1:0]   sAddr_q, sAddr_d;
   logic [DATA_W-1:0]   sWdata_q, sWdata_d;
   logic [STRB_W-1:0]   sWstrb_q, sWstrb_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                err_q, err_d;

   master_idx_t         winner;
   logic                grant;
   logic                waitCycle;
   logic                expired;
   logic                respValid;

   assign winner    = pickWinner(m0_req, m1_req, last_q);
   assign waitCycle = (state_q == ACCESS) && !s_ready;

   bus_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk       (clk),
      .reset     (reset),
      .clear_i   (grant),
      .en_i      (waitCycle),
      .expired_o (expired)
   );

   // Arbiter FSM. Master request fields are only looked at in IDLE; once an
   // access is granted the slave-side copy is frozen until the next grant.
   // A slave completion wins over a watchdog expiry landing in the same cycle.
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      last_d   = last_q;
      sWe_d    = sWe_q;
      sAddr_d  = sAddr_q;
      sWdata_d = sWdata_q;
      sWstrb_d = sWstrb_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      grant    = 1'b0;
      case (state_q)
         IDLE: begin
            if (m0_req || m1_req) begin
               grant    = 1'b1;
               owner_d  = winner;
               last_d   = winner;
               sWe_d    = winner ? m1_we    : m0_we;
               sAddr_d  = winner ? m1_addr  : m0_addr;
               sWdata_d = winner ? m1_wdata : m0_wdata;
               sWstrb_d = winner ? m1_wstrb : m0_wstrb;
               state_d  = ACCESS;
            end
         end
         ACCESS: begin
            if (s_ready) begin
               rdata_d = sWe_q ? '0 : s_rdata;
               err_d   = 1'b0;
               state_d = RESP;
            end else if (expired) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers. Reset abandons any access in flight, so
   // no ready is ever issued for it and the slave strobe drops next cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         owner_q  <= 1'b0;
         last_q   <= 1'b1;
         sWe_q    <= 1'b0;
         sAddr_q  <= '0;
         sWdata_q <= '0;
         sWstrb_q <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         last_q   <= last_d;
         sWe_q    <= sWe_d;
         sAddr_q  <= sAddr_d;
         sWdata_q <= sWdata_d;
         sWstrb_q <= sWstrb_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   assign s_req   = (state_q == ACCESS);
   assign s_we    = sWe_q;
   assign s_addr  = sAddr_q;
   assign s_wdata = sWdata_q;
   assign s_wstrb = sWstrb_q;

   // Only the owner sees the response; the other master reads all zeros.
   assign respValid = (state_q == RESP);
   assign m0_ready  = respValid && (owner_q == 1'b0);
   assign m1_ready  = respValid && (owner_q == 1'b1);
   assign m0_rdata  = m0_ready ? rdata_q : '0;
   assign m1_rdata  = m1_ready ? rdata_q : '0;
   assign m0_err    = m0_ready && err_q;
   assign m1_err    = m1_ready && err_q;

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master, one-slave arbiter that shares the SOC's single-port memory/peripheral bus between the multicycle RISC-V core (master 0) and a secondary requester such as a loader or debug port (master 1). It serialises accesses, uses round-robin priority, and registers the response back to the winner. A timeout watchdog ends any access the slave never acknowledges. Instantiated in `SOC` between the CPU memory port and the RAM/LED decode.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; `DATA_W/8` byte strobes
- `TIMEOUT`, 255, max cycles waiting for `s_ready`; 0 disables the watchdog

Ports (`i` ∈ {0,1}):
- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `m{i}_req`  in  1  access request, held until `m{i}_ready`
- `m{i}_we`  in  1  1=write, 0=read
- `m{i}_addr`  in  ADDR_W  byte address
- `m{i}_wdata`  in  DATA_W  write data
- `m{i}_wstrb`  in  DATA_W/8  byte enables (writes only)
- `m{i}_ready`  out  1  one-cycle completion pulse
- `m{i}_rdata`  out  DATA_W  read data, valid while `m{i}_ready`
- `m{i}_err`  out  1  with `m{i}_ready`: access timed out
- `s_req`  out  1  slave access strobe, held until `s_ready`
- `s_we`, `s_addr`, `s_wdata`, `s_wstrb`  out  as master  registered copy of granted request
- `s_ready`  in  1  slave completion, same cycle as valid `s_rdata`
- `s_rdata`  in  DATA_W  slave read data

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any `m*_req`, pick winner, latch its we/addr/wdata/wstrb into slave regs, set `owner`, clear timeout counter -> ACCESS. Else stay.
- Priority: single requester wins; both -> master ≠ `last` (`last` updated to winner at each grant). Reset sets `last`=1, so master 0 wins the first tie.
- ACCESS: `s_req`=1, slave regs stable. On `s_ready`: capture `s_rdata` (reads; writes capture 0), `err`=0 -> RESP. Else counter +1; when counter reaches TIMEOUT (TIMEOUT≠0): drop `s_req`, rdata=0, `err`=1 -> RESP.
- RESP: `m{owner}_ready`=1, `m{owner}_rdata`/`err` driven from capture regs, other master's outputs 0 -> IDLE.
- Master request fields are sampled only in IDLE; changes during ACCESS/RESP are ignored. Master may present a new request the cycle after its ready.
- Non-owner `m_ready`, `m_err` are always 0; `m_rdata` is 0 unless ready.

## Timing
- Reset: state IDLE, `last`=1, counter 0; all outputs 0 (`s_req`, `s_*` fields, `m*_ready`, `m*_rdata`, `m*_err`).
- Reset mid-access: abandon at once, `s_req`=0 next cycle, no `m_ready` issued; slave tolerates the dropped access.
- Latency: request seen in IDLE at edge k -> `s_req` high from k+1; `s_ready` at edge j -> `m_ready` at j+1. Zero-wait slave: 3 cycles request-to-ready; back-to-back throughput one access per 3 cycles.
- `s_ready` outside ACCESS is ignored.
- Timeout: with `s_ready` never high, `s_req` is high TIMEOUT cycles, then `m_ready`+`m_err` one cycle later.
- Counter width `$clog2(TIMEOUT+1)`, saturating; no wrap.
- A second master's request arriving during ACCESS/RESP waits; it is granted in the following IDLE.

## Structure
- Package `soc_bus_pkg`: `arb_state_t` enum {IDLE, ACCESS, RESP}, `master_idx_t` (1 bit), default `ADDR_W`/`DATA_W` localparams, shared with the SOC decode.
- Sub-module `bus_timeout_ctr`: clear/enable/`expired`, parameterised on TIMEOUT, reused by other bus bridges.
- Arbiter FSM, priority pick and response muxing stay in this module.

## Test plan
- Single read: m0 read addr 0x0000_0010, slave ready 2 cycles after `s_req`, rdata 0xDEAD_BEEF -> `s_addr`=0x10, `m0_ready` pulse once with 0xDEAD_BEEF, `m0_err`=0, m1 outputs 0.
- Tie after reset: both request in the same cycle -> m0 granted first, m1 second. Both hold requests -> grants alternate 0,1,0,1.
- Write strobes: m1 write 0x1234_5678 strb 0b0011 addr 0x8000_0004 -> slave sees exact fields; `m1_rdata`=0.
- Timeout: TIMEOUT=4, slave never ready -> `s_req` high 4 cycles, then `m0_ready`=`m0_err`=1, rdata 0; next request served normally.
- Reset during ACCESS: assert `reset` while `s_req`=1 -> next cycle all outputs 0, no ready. After release, tie -> m0 wins.
- Request-field change during ACCESS: m0 changes addr mid-access -> `s_addr` keeps the latched value.
